// File: rtl/ps2_keyboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_pkg
// Purpose  : Shared constants, types and helpers for the PS/2 keyboard path.
// Revision : 1.0  initial release
// ============================================================================
package ps2_keyboard_pkg;

  // Device-to-host frame: start, 8 data bits, odd parity, stop.
  localparam int PS2_FRAME_BITS = 11;
  localparam int SCAN_CODE_W    = 8;

  // Bit index of the stop bit within a frame (counter value on the 11th strobe).
  localparam logic [3:0] PS2_STOP_IDX = 4'(PS2_FRAME_BITS - 1);

  // Scan-code prefixes consumed by the downstream decoder.
  localparam logic [SCAN_CODE_W-1:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [SCAN_CODE_W-1:0] PS2_EXT_PREFIX   = 8'hE0;

  typedef logic [SCAN_CODE_W-1:0] scan_code_t;

  // Data bits plus parity bit must contain an odd number of ones.
  function automatic logic ps2_odd_parity_ok(input logic [SCAN_CODE_W:0] bits);
    return ^bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Purpose  : Synchronises an asynchronous PS/2 line, rejects pulses shorter
//            than FILTER_LEN clocks and strobes on each filtered 1->0 edge.
// Revision : 1.0  initial release
// ============================================================================
module ps2_line_filter
  import ps2_keyboard_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic fall_o
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  level_q;
  logic                  level_d;

  // Two-flop synchroniser; the idle PS/2 line is high, so reset to 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line_i};
    end
  end

  // History of synchronised samples and the filtered level derived from it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q  <= '1;
      level_q <= 1'b1;
    end else begin
      hist_q  <= {hist_q[FILTER_LEN-2:0], sync_q[1]};
      level_q <= level_d;
    end
  end

  // Level changes only once the whole history agrees; otherwise it holds.
  always_comb begin
    level_d = level_q;
    if (~|hist_q) begin
      level_d = 1'b0;
    end else if (&hist_q) begin
      level_d = 1'b1;
    end
  end

  // One-cycle strobe in the cycle the filtered level is about to drop.
  assign fall_o = level_q & ~level_d;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard
// Purpose  : PS/2 keyboard receiver. Deserialises device-to-host frames into
//            scan codes held behind a sticky ready flag cleared by read.
// Revision : 1.0  initial release
// ============================================================================
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   clock50,
  input  logic                   reset,
  input  logic                   keyboard_clk,
  input  logic                   keyboard_data,
  input  logic                   read,
  output logic                   scan_ready,
  output logic [SCAN_CODE_W-1:0] scan_code
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic                 strobe;
  logic [1:0]           dsync_q;
  logic                 data_bit;

  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [SCAN_CODE_W:0] shift_q,   shift_d;    // data bits [7:0], parity [8]
  scan_code_t           code_q,    code_d;
  logic                 ready_q,   ready_d;
  logic [TO_W-1:0]      to_cnt_q,  to_cnt_d;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk_i  (clock50),
    .rst_ni (reset),
    .line_i (keyboard_clk),
    .fall_o (strobe)
  );

  // Data line only needs synchronising: it is sampled well after it settles,
  // because the clock path adds the filter delay on top.
  always_ff @(posedge clock50 or negedge reset) begin
    if (!reset) begin
      dsync_q <= 2'b11;
    end else begin
      dsync_q <= {dsync_q[0], keyboard_data};
    end
  end

  assign data_bit = dsync_q[1];

  // Frame, output and timeout state registers.
  always_ff @(posedge clock50 or negedge reset) begin
    if (!reset) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      code_q    <= '0;
      ready_q   <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      code_q    <= code_d;
      ready_q   <= ready_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Deserialiser, completion check, read handshake and idle timeout.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    code_d    = code_q;
    ready_d   = ready_q;
    to_cnt_d  = to_cnt_q;

    // Acknowledge first so that a completing frame below takes priority.
    if (read) begin
      ready_d = 1'b0;
    end

    if (strobe) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd0) begin
        // A high start bit means we are out of step; stay put and resync.
        if (!data_bit) begin
          bit_cnt_d = 4'd1;
        end
      end else if (bit_cnt_q == PS2_STOP_IDX) begin
        bit_cnt_d = 4'd0;
        if (data_bit && ps2_odd_parity_ok(shift_q)) begin
          code_d  = shift_q[SCAN_CODE_W-1:0];
          ready_d = 1'b1;
        end
      end else begin
        // LSB arrives first, so shift in from the top.
        shift_d   = {data_bit, shift_q[SCAN_CODE_W:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        shift_d   = '0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  assign scan_ready = ready_q;
  assign scan_code  = code_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keyboard
// Purpose  : Directed self-checking bench for the PS/2 keyboard receiver.
//            PS/2 timing is scaled down (short half-periods and timeout).
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_keyboard;
  import ps2_keyboard_pkg::*;

  localparam int FLT = 8;
  localparam int TO  = 2000;
  localparam int H   = 50;   // PS/2 clock half-period in clock50 cycles

  logic       clock50 = 1'b0;
  logic       reset;
  logic       kclk;
  logic       kdat;
  logic       read;
  logic       scan_ready;
  logic [7:0] scan_code;

  int passed = 0;
  int total  = 0;
  int lat;

  always #10 clock50 = ~clock50;

  ps2_keyboard #(
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock50       (clock50),
    .reset         (reset),
    .keyboard_clk  (kclk),
    .keyboard_data (kdat),
    .read          (read),
    .scan_ready    (scan_ready),
    .scan_code     (scan_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock50);
  endtask

  task automatic read_pulse();
    @(negedge clock50); read = 1'b1;
    @(negedge clock50); read = 1'b0;
  endtask

  // Sends the first nbits of a frame. lat records the first low-phase cycle
  // of the last bit at which scan_ready is seen high. read_at>0 raises read
  // for exactly one cycle at that point of the last bit's low phase.
  task automatic send_frame(input logic [7:0] data, input logic par_flip,
                            input logic stop_bit, input int nbits,
                            input logic glitch, input int read_at);
    logic [10:0] fr;
    fr  = {stop_bit, (~^data) ^ par_flip, data, 1'b0};
    lat = -1;
    for (int b = 0; b < nbits; b++) begin
      @(negedge clock50); kdat = fr[b];
      for (int i = 1; i < H; i++) begin
        @(negedge clock50);
        if (glitch && i == 20) kclk = 1'b0;
        if (glitch && i == 25) kclk = 1'b1;
      end
      @(negedge clock50); kclk = 1'b0;
      for (int i = 1; i <= H; i++) begin
        @(negedge clock50);
        read = (read_at > 0) && (b == nbits - 1) && (i == read_at);
        if (b == nbits - 1 && lat < 0 && scan_ready) lat = i;
      end
      kclk = 1'b1;
    end
    kdat = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    kclk  = 1'b1;
    kdat  = 1'b1;
    read  = 1'b0;
    idle(5);
    chk("reset_code",  {24'd0, scan_code}, 32'h00);
    chk("reset_ready", {31'd0, scan_ready}, 32'd0);
    reset = 1'b1;
    idle(20);

    // Basic frame and completion latency
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 0);
    chk("lat_1c",   {31'd0, (lat > 0 && lat <= FLT + 4)}, 32'd1);
    chk("code_1c",  {24'd0, scan_code}, 32'h1C);
    chk("ready_1c", {31'd0, scan_ready}, 32'd1);

    // Acknowledge, then a second code
    read_pulse();
    chk("ack_ready", {31'd0, scan_ready}, 32'd0);
    chk("ack_code",  {24'd0, scan_code}, 32'h1C);
    idle(10);
    send_frame(PS2_BREAK_PREFIX, 1'b0, 1'b1, 11, 1'b0, 0);
    chk("lat_f0",   {31'd0, (lat > 0 && lat <= FLT + 4)}, 32'd1);
    chk("code_f0",  {24'd0, scan_code}, 32'hF0);
    chk("ready_f0", {31'd0, scan_ready}, 32'd1);

    // Bad parity, then bad stop: both dropped
    read_pulse();
    chk("ack2_ready", {31'd0, scan_ready}, 32'd0);
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 0);
    idle(20);
    chk("badpar_ready", {31'd0, scan_ready}, 32'd0);
    chk("badpar_code",  {24'd0, scan_code}, 32'hF0);
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0, 0);
    idle(20);
    chk("badstop_ready", {31'd0, scan_ready}, 32'd0);
    chk("badstop_code",  {24'd0, scan_code}, 32'hF0);

    // Short clock glitches between real edges are ignored
    send_frame(8'h32, 1'b0, 1'b1, 11, 1'b1, 0);
    chk("glitch_code",  {24'd0, scan_code}, 32'h32);
    chk("glitch_ready", {31'd0, scan_ready}, 32'd1);
    read_pulse();
    idle(300);
    chk("glitch_no_extra", {31'd0, scan_ready}, 32'd0);

    // Partial frame abandoned by the idle timeout
    send_frame(8'h24, 1'b0, 1'b1, 4, 1'b0, 0);
    idle(TO + 1000);
    chk("partial_ready", {31'd0, scan_ready}, 32'd0);
    send_frame(8'h24, 1'b0, 1'b1, 11, 1'b0, 0);
    chk("timeout_code",  {24'd0, scan_code}, 32'h24);
    chk("timeout_ready", {31'd0, scan_ready}, 32'd1);

    // Reset mid-frame
    read_pulse();
    send_frame(8'h24, 1'b0, 1'b1, 5, 1'b0, 0);
    @(negedge clock50); reset = 1'b0;
    #1;
    chk("midrst_code",  {24'd0, scan_code}, 32'h00);
    chk("midrst_ready", {31'd0, scan_ready}, 32'd0);
    idle(3);
    reset = 1'b1;
    idle(20);
    send_frame(8'h24, 1'b0, 1'b1, 11, 1'b0, 0);
    chk("postrst_code",  {24'd0, scan_code}, 32'h24);
    chk("postrst_ready", {31'd0, scan_ready}, 32'd1);

    // Read on the completion edge: completion wins
    chk("pre15_ready", {31'd0, scan_ready}, 32'd1);
    send_frame(8'h15, 1'b0, 1'b1, 11, 1'b0, FLT + 2);
    chk("coll_code",  {24'd0, scan_code}, 32'h15);
    chk("coll_ready", {31'd0, scan_ready}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
PS/2 keyboard receiver on the system clock domain. It deglitches the PS/2 clock line and deserialises 11-bit device-to-host frames into 8-bit scan codes. It presents each code with a sticky scan_ready flag that stays set until the consumer acknowledges it with read. It feeds the keyboard decoder, which pulses read through a one-shot and keeps the scan-code history.

Parameters:
FILTER_LEN, 8, number of consecutive equal samples of keyboard_clk needed to change the filtered clock level.
TIMEOUT_CYCLES, 100000, idle clock50 cycles (2 ms at 50 MHz) after which a partial frame is discarded.

Ports:
clock50  input  1  system clock, 50 MHz; all state on its rising edge.
reset  input  1  asynchronous, active-low reset. Integrators tie it high or drive it from a debounced key.
keyboard_clk  input  1  raw PS/2 clock from the connector; asynchronous.
keyboard_data  input  1  raw PS/2 data from the connector; asynchronous.
read  input  1  acknowledge, level-sensitive; clears scan_ready.
scan_ready  output  1  a valid, unacknowledged scan code is held.
scan_code  output  8  last complete scan code received.

Behaviour:
- Reset (reset=0, asynchronous): scan_code=8'h00, scan_ready=0, bit counter=0, filtered clock=1, shift register cleared, timeout counter=0.
- Synchronisation: keyboard_clk and keyboard_data each pass through a 2-flop synchroniser.
- Filtering:
  - Synchronised clock shifts into a FILTER_LEN-bit history register.
  - Filtered clock goes 0 when the history is all 0s, and 1 when it is all 1s; otherwise it holds.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Edge detection: a falling edge is a filtered-clock transition 1->0. It produces a one-cycle sample strobe.
- Frame format, sampled on each strobe: bit0 start=0, bits1-8 data LSB first, bit9 odd parity, bit10 stop=1. The 4-bit counter runs 0..10.
- Frame completion (11th strobe):
  - Frame is valid when start=0, stop=1 and XOR(data, parity)=1.
  - Valid frame: scan_code<=data and scan_ready<=1 on the cycle after the strobe. Latency is 1 clock after the strobe, about FILTER_LEN+3 clocks after the raw falling edge.
  - Invalid frame: silently dropped; scan_code and scan_ready unchanged.
  - The counter returns to 0 in either case.
- Start-bit check: if bit0 samples as 1, the counter stays at 0 (resynchronisation).
- Timeout:
  - Counter runs while the bit counter is nonzero, and clears on every strobe.
  - On reaching TIMEOUT_CYCLES, the bit counter returns to 0 and partial data is discarded.
- Read handshake:
  - read=1 on a clock edge clears scan_ready on that edge.
  - scan_code is held, not cleared.
  - read while scan_ready=0 has no effect.
- Simultaneous read and valid completion: completion wins; scan_ready=1 holding the new code.
- Overrun: a valid frame while scan_ready=1 overwrites scan_code; scan_ready stays 1. There is no overrun flag.
- Reset mid-frame: partial frame is lost; the next complete frame is received normally.
- Host-to-device transmission is not supported; both PS/2 lines are inputs only.

Decomposition:
- Shared package constants: PS2_FRAME_BITS=11, SCAN_CODE_W=8, break prefix 8'hF0, extended prefix 8'hE0. The decoder uses the prefixes.
- One sub-module: ps2_line_filter, containing the synchroniser, FILTER_LEN history and falling-edge strobe. It is instantiated for the clock line.
- The data line uses only the 2-flop synchroniser.

Test Plan:
- Frame 0x1C (start 0, data LSB-first, parity 0, stop 1), 20 us half-periods -> scan_code=8'h1C, scan_ready=1 within FILTER_LEN+4 clocks of the 11th falling edge.
- After the above, pulse read=1 for one clock -> scan_ready=0 next edge; scan_code stays 8'h1C. Then send 0xF0 (parity 1) -> scan_code=8'hF0, scan_ready=1.
- Send 0x1C with parity bit 1, and separately with stop bit 0 -> scan_ready remains 0, scan_code unchanged.
- Inject 5-cycle low glitches on keyboard_clk between valid edges of a 0x32 frame -> scan_code=8'h32 exactly once; no extra bits shifted.
- Send 4 bits of a frame, idle 3 ms, then a full 0x24 frame -> scan_code=8'h24, scan_ready=1. Repeat with reset=0 asserted mid-frame instead of idling -> outputs zero immediately, then 0x24 received correctly.
- Hold read=1 on the same clock as the 0x15 frame completes, with scan_ready=1 from an earlier code -> scan_code=8'h15, scan_ready=1.
